product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PROD_W, 64, width of the incoming unsigned product word
- LEN_W, 8, width of the frame-length field
- ACC_W, 72, accumulator and output width; must be at least PROD_W+LEN_W
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted)
- clear, input, 1, synchronous abort; discards the current frame
- product, input, PROD_W, unsigned product from the upstream registered multiplier
- in_valid, input, 1, product is valid this cycle
- in_ready, output, 1, block can accept a product this cycle
- frame_len, input, LEN_W, products per frame; sampled only on the first accept of a frame; 0 means 2^LEN_W
- sum, output, ACC_W, unsigned frame sum; valid while out_valid=1
- out_valid, output, 1, sum is available
- out_ready, input, 1, downstream accepts sum
- frame_cnt, output, 16, number of completed frames handed off; wraps modulo 2^16

Function
REQ-003 An input accept SHALL be defined as in_valid=1 and in_ready=1 at a rising clk edge; an output handoff SHALL be defined as out_valid=1 and out_ready=1 at a rising clk edge.
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-005 IDLE: in_ready=1 and out_valid=0.
- On accept: acc<=zero-extended product, cnt<=1, len_q<=frame_len.
- Next state is DONE if the effective length is 1, otherwise ACCUM.
REQ-006 ACCUM: in_ready=1 and out_valid=0.
- On accept: acc<=acc+product, cnt<=cnt+1.
- Enter DONE on the accept that makes cnt equal the effective length.
- Without an accept: hold all state.
REQ-007 DONE: in_ready=0, out_valid=1, sum=acc, held stable until handoff.
- On handoff: go to IDLE and increment frame_cnt.
REQ-008 out_valid SHALL rise in the cycle after the edge that accepts the frame's last product (latency 1); IDLE is re-entered the cycle after handoff, so the next frame starts no earlier than 1 cycle after handoff.
REQ-009 Addition SHALL be unsigned and ACC_W wide; with the defaults no overflow is possible (2^8 terms × (2^64−1) < 2^72). Overflow behaviour is unspecified for non-default parameters that violate the ACC_W ≥ PROD_W+LEN_W rule.
REQ-010 The count SHALL use LEN_W+1 bits, so that a length of 2^LEN_W (frame_len=0) terminates correctly.
REQ-011 frame_len changes after the first accept of a frame SHALL have no effect on that frame.
REQ-012 clear=1 SHALL force IDLE, acc=0 and cnt=0 at the next edge from any state, overriding any simultaneous accept or handoff; frame_cnt is not incremented.
REQ-013 The sum output SHALL be driven with acc in all states; only out_valid qualifies it.
REQ-014 in_valid while in DONE SHALL be ignored; no product is consumed.

Reset
REQ-015 While reset=0, asynchronously: state=IDLE, acc=0, cnt=0, len_q=0, frame_cnt=0, hence out_valid=0, sum=0 and in_ready=1.
REQ-016 Reset asserted mid-frame or in DONE SHALL discard the partial or pending sum with no handoff.
REQ-017 After reset deassertion, the first edge SHALL be able to accept a product.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- frame_len=3; products 5, 7, 11 on consecutive cycles -> out_valid=1 one cycle after the third accept, sum=23; frame_cnt becomes 1 after handoff.
- frame_len=1; product 0xFFFF_FFFF_FFFF_FFFF -> out_valid the next cycle, sum=0x00_FFFF_FFFF_FFFF_FFFF.
- frame_len=0; 256 products, each 0xFFFF_FFFF_FFFF_FFFF -> sum=0xFF_FFFF_FFFF_FFFF_FF00, with no early out_valid.
- frame_len=2; out_ready held 0 for 5 cycles while in_valid=1 -> in_ready=0, sum stable, no product consumed; handoff occurs when out_ready rises.
- frame_len=4; clear after 2 accepts -> IDLE; a new frame 1, 2, 3, 4 yields sum=10.
- frame_len=4; reset=0 pulsed after 2 accepts -> all outputs at reset values immediately (before the next edge), frame_cnt=0.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums a frame of frame_len unsigned products and hands the total downstream
// through a valid/ready handshake. A frame_len of 0 means 2^LEN_W products.
module product_accumulator #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [ACC_W-1:0]  sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       frame_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W:0]   r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic [15:0]      r_frame_cnt;

  logic [1:0]       w_state_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [LEN_W:0]   w_cnt_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [15:0]      w_frame_cnt_nxt;

  logic             w_accept;
  logic             w_handoff;
  logic [ACC_W-1:0] w_prod_ext;
  logic [LEN_W:0]   w_cnt_inc;
  logic [LEN_W:0]   w_len_in_eff;
  logic [LEN_W:0]   w_len_q_eff;

  // A zero length field encodes 2^LEN_W, so the count runs one bit wider.
  function automatic logic [LEN_W:0] eff_len(input logic [LEN_W-1:0] l);
    eff_len = (l == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, l};
  endfunction

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign out_valid    = (r_state == S_DONE);
  assign sum          = r_acc;
  assign frame_cnt    = r_frame_cnt;

  assign w_accept     = in_valid && in_ready;
  assign w_handoff    = out_valid && out_ready;
  assign w_prod_ext   = ACC_W'(product);
  assign w_cnt_inc    = r_cnt + (LEN_W + 1)'(1);
  assign w_len_in_eff = eff_len(frame_len);
  assign w_len_q_eff  = eff_len(r_len_q);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len_q;
    w_frame_cnt_nxt = r_frame_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_prod_ext;
          w_cnt_nxt   = (LEN_W + 1)'(1);
          w_len_nxt   = frame_len;
          w_state_nxt = (w_len_in_eff == (LEN_W + 1)'(1)) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = r_acc + w_prod_ext;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == w_len_q_eff) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_handoff) begin
          w_state_nxt     = S_IDLE;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over any accept or handoff seen on the same edge.
    if (clear) begin
      w_state_nxt     = S_IDLE;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_frame_cnt_nxt = r_frame_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks of product_accumulator against a frame-level
// reference model (running sum, term count, pending-result flag).
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [63:0] product;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  frame_len;
  logic [71:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [71:0] m_acc;
  int          m_n;
  int          m_target;
  bit          m_pending;
  logic [15:0] m_frames;

  logic [71:0] held_sum;
  logic [63:0] ones64;

  product_accumulator #(.PROD_W(64), .LEN_W(8), .ACC_W(72)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .product   (product),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frame_len (frame_len),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc     = '0;
    m_n       = 0;
    m_target  = 0;
    m_pending = 0;
    m_frames  = '0;
  endtask

  // Frame-level behaviour at one rising edge, using the inputs held across it.
  task automatic model_edge();
    if (clear) begin
      m_acc     = '0;
      m_n       = 0;
      m_pending = 0;
    end else if (m_pending) begin
      if (out_ready) begin
        m_pending = 0;
        m_n       = 0;
        m_frames  = m_frames + 16'd1;
      end
    end else if (in_valid) begin
      if (m_n == 0) begin
        m_target = (frame_len == 8'd0) ? 256 : int'(frame_len);
        m_acc    = {8'd0, product};
      end else begin
        m_acc = m_acc + {8'd0, product};
      end
      m_n++;
      if (m_n == m_target) m_pending = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"},  {71'd0, in_ready},  {71'd0, !m_pending});
    check({tag, ".out_valid"}, {71'd0, out_valid}, {71'd0, m_pending});
    check({tag, ".sum"},       sum,                m_acc);
    check({tag, ".frame_cnt"}, {56'd0, frame_cnt}, {56'd0, m_frames});
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic [7:0] fl,
                       input logic ordy, input logic clr);
    in_valid  = v;
    product   = p;
    frame_len = fl;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    ones64 = '1;
    drive(1'b0, '0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Three-term frame: 5 + 7 + 11
    drive(1'b1, 64'd5, 8'd3, 1'b0, 1'b0);  tick("f3a");
    drive(1'b1, 64'd7, 8'd9, 1'b0, 1'b0);  tick("f3b");
    drive(1'b1, 64'd11, 8'd1, 1'b0, 1'b0); tick("f3c");
    check("f3.valid_latency", {71'd0, out_valid}, 72'd1);
    check("f3.sum", sum, 72'd23);
    drive(1'b0, '0, 8'd3, 1'b1, 1'b0);     tick("f3ho");
    check("f3.frame_cnt", {56'd0, frame_cnt}, 72'd1);

    // Single-term frame of the largest product
    drive(1'b1, ones64, 8'd1, 1'b0, 1'b0); tick("f1");
    check("f1.sum", sum, 72'h00_FFFF_FFFF_FFFF_FFFF);
    drive(1'b0, '0, 8'd1, 1'b1, 1'b0);     tick("f1ho");

    // frame_len=0 runs 256 terms; later frame_len values must be ignored
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, ones64, (i == 0) ? 8'd0 : 8'($urandom_range(1, 255)), 1'b1, 1'b0);
      tick("f256");
    end
    check("f256.valid", {71'd0, out_valid}, 72'd1);
    check("f256.sum", sum, 72'hFF_FFFF_FFFF_FFFF_FF00);
    drive(1'b0, '0, 8'd0, 1'b1, 1'b0);     tick("f256ho");

    // Backpressure while the result is pending
    drive(1'b1, 64'd100, 8'd2, 1'b0, 1'b0); tick("bp_a");
    drive(1'b1, 64'd200, 8'd2, 1'b0, 1'b0); tick("bp_b");
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'($urandom), 8'd2, 1'b0, 1'b0);
      tick("bp_hold");
      check("bp.in_ready", {71'd0, in_ready}, 72'd0);
      check("bp.sum_stable", sum, 72'd300);
    end
    check("bp.held", held_sum, 72'd300);
    drive(1'b0, '0, 8'd2, 1'b1, 1'b0);      tick("bp_ho");
    check("bp.idle_after_ho", {71'd0, out_valid}, 72'd0);

    // Abort after two terms, then a clean 1+2+3+4 frame
    drive(1'b1, 64'd50, 8'd4, 1'b0, 1'b0);  tick("clr_a");
    drive(1'b1, 64'd60, 8'd4, 1'b0, 1'b0);  tick("clr_b");
    drive(1'b1, 64'd70, 8'd4, 1'b1, 1'b1);  tick("clr");
    check("clr.sum", sum, 72'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 8'd4, 1'b0, 1'b0);
      tick("clr_new");
    end
    check("clr.new_sum", sum, 72'd10);
    drive(1'b0, '0, 8'd4, 1'b1, 1'b0);      tick("clr_ho");

    // Asynchronous reset mid-frame; first edge after release must accept
    drive(1'b1, 64'd9, 8'd4, 1'b0, 1'b0);   tick("rst_a");
    drive(1'b1, 64'd8, 8'd4, 1'b0, 1'b0);   tick("rst_b");
    drive(1'b0, '0, 8'd4, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    check("rst.frame_cnt", {56'd0, frame_cnt}, 72'd0);
    #2;
    reset = 1'b1;
    drive(1'b1, 64'd42, 8'd1, 1'b0, 1'b0);  tick("rst_first");
    check("rst.first_accept", sum, 72'd42);
    drive(1'b0, '0, 8'd1, 1'b1, 1'b0);      tick("rst_ho");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0),
            {32'($urandom), 32'($urandom)},
            8'($urandom_range(0, 6)),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 40) == 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
